fir_interp2: RTL and testbench
==============================

# fir_interp2

Factor-2 interpolating filter for the Red Pitaya shift-coefficient FIR path. It takes 8-bit unsigned samples through a valid/ready handshake and emits two 10-bit filtered samples per input: the even-phase output first, then the odd-phase output. The arithmetic is a polyphase, multiplier-free equivalent of zero-stuffing followed by the team's 5-tap power-of-two FIR. It sits on the DAC-side path, opposite the decimating/receive FIR chain.

## Interface
- `DW`, 8, input sample width (unsigned).
- `OW`, 10, output width (unsigned, zero-extended sum).
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `in_data` input DW: input sample x[k].
- `in_valid` input 1: in_data is valid.
- `in_ready` output 1: block accepts in_data this cycle.
- `out_data` output OW: filtered sample y[m].
- `out_valid` output 1: out_data is valid.
- `out_ready` input 1: downstream accepts out_data this cycle.

## Operation
- Shift set s0..s4 = 5,4,3,2,1; each tap is `sample >> s_i` on the 8-bit value, truncated, with no rounding.
- History registers h0 (newest), h1, h2 are all DW wide.
- Even output: (h0>>5) + (h1>>3) + (h2>>1).
- Odd output: (h0>>4) + (h1>>2).
- All sums are zero-extended to OW. Maximum values are 165 (even) and 78 (odd), so sums never overflow.
- States:
  - IDLE: no output pending.
  - EVEN: even output presented.
  - ODD: odd output presented.
- Input accept occurs when `in_valid && in_ready`.
  - History shifts: h2<=h1, h1<=h0, h0<=in_data.
  - out_data <= even sum computed from the post-shift history.
  - State goes to EVEN.
- EVEN with `out_ready`: out_data <= odd sum of the current h0,h1; state goes to ODD.
- ODD with `out_ready`:
  - With a simultaneous accept, the input-accept action applies and the state goes to EVEN.
  - Otherwise the state goes to IDLE.
- `in_ready` = (state==IDLE) || (state==ODD && out_ready). It is combinational from out_ready.
- `out_valid` = (state==EVEN || state==ODD), decoded from the state register.
- Backpressure: while out_valid && !out_ready, out_data, state and history hold.
- in_valid while in_ready=0: no effect; the upstream must hold its data.

## Timing
- Reset values:
  - state = IDLE.
  - h0, h1, h2 = 0.
  - out_data = 0.
  - out_valid = 0.
  - in_ready = 1 (first cycle after reset).
- Latency: an accept at edge N gives out_valid=1 with the even sample in the cycle after edge N. The odd sample follows one cycle after the even handshake.
- Throughput: with out_ready held high and in_valid held high, the block gives one output per cycle and one input per two cycles. in_ready toggles 1,0,1,0…
- Reset mid-operation: pending even/odd outputs are dropped and history is cleared. No output is produced from pre-reset data.
- out_valid never deasserts without a handshake, except on reset.

## Structure
- Package `fir_shift_pkg` holds:
  - the shift constants S0..S4;
  - DW and OW defaults;
  - the state enum {IDLE, EVEN, ODD}.
- The same shift constants are reused by the receive-side FIR.
- Sub-module `fir_phase_sum` is combinational. It takes (a,b,c,phase) and returns the even or odd sum. It is instantiated once and fed by a mux selecting the post-shift history (on accept) or the current history (on EVEN handshake).
- The top level holds the FSM, the history registers and the out_data register.

## Test plan
- Reset, then impulse 255 followed by zeros, with out_ready=1 → outputs 7,15,31,63,127,0,0,0.
- Constant 255 stream at full rate → steady-state pairs 165,78. in_ready pattern 1,0,1,0 with no gaps in out_valid after the first output.
- Backpressure: accept 255, then hold out_ready=0 for 5 cycles → out_data stays 7 and out_valid stays 1. in_ready=0 and history is unchanged.
- Simultaneous ODD handshake and new input (32): no idle cycle; next even output = (32>>5)+(h1>>3)+(h2>>1). For prior history 0 it is 1.
- Assert rst while in ODD with out_ready=0 → next cycle out_valid=0, out_data=0, in_ready=1. A new input of 64 then yields even=2, odd=4.
- in_valid pulses while in EVEN with out_ready=0 → sample ignored. The output sequence matches the reference model of accepted samples only.

Source files
------------

// File: rtl/fir_shift_pkg.sv
// Shared constants for the power-of-two shift FIR family (interpolator and receive chain).
// Holds the tap shift set, default widths and the interpolator phase state encoding.
package fir_shift_pkg;

    localparam int S0 = 5;
    localparam int S1 = 4;
    localparam int S2 = 3;
    localparam int S3 = 2;
    localparam int S4 = 1;

    localparam int DW_DEF = 8;
    localparam int OW_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } state_t;

endpackage

// File: rtl/fir_phase_sum.sv
// Combinational polyphase adder: the even phase uses taps S0/S2/S4, the odd phase S1/S3.
// Operands are zero-extended to OW before summing, which cannot overflow at DW=8, OW=10.
module fir_phase_sum
    import fir_shift_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic          phase,
    output logic [OW-1:0] sum
);

    logic [OW-1:0] even_sum;
    logic [OW-1:0] odd_sum;

    always_comb begin
        even_sum = OW'(a >> S0) + OW'(b >> S2) + OW'(c >> S4);
        odd_sum  = OW'(a >> S1) + OW'(b >> S3);
        sum      = phase ? odd_sum : even_sum;
    end

endmodule

// File: rtl/fir_interp2.sv
// Factor-2 interpolating shift FIR: one input sample yields an even then an odd output.
//   state | meaning
//   IDLE  | no output pending, ready for a new sample
//   EVEN  | even-phase output presented
//   ODD   | odd-phase output presented, may accept a new sample on handshake
module fir_interp2
    import fir_shift_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    state_t        state, state_nxt;
    logic [DW-1:0] h0, h1, h2;
    logic [DW-1:0] sa, sb, sc;
    logic          sphase;
    logic [OW-1:0] sum;
    logic          accept;
    logic          even_hs;

    assign in_ready  = (state == IDLE) || (state == ODD && out_ready);
    assign out_valid = (state == EVEN) || (state == ODD);
    assign accept    = in_valid && in_ready;
    assign even_hs   = (state == EVEN) && out_ready;

    // On accept the adder sees the history as it will be after the shift.
    always_comb begin
        sa     = h0;
        sb     = h1;
        sc     = h2;
        sphase = 1'b1;
        if (accept) begin
            sa     = in_data;
            sb     = h0;
            sc     = h1;
            sphase = 1'b0;
        end
    end

    fir_phase_sum #(.DW(DW), .OW(OW)) u_sum (
        .a     (sa),
        .b     (sb),
        .c     (sc),
        .phase (sphase),
        .sum   (sum)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EVEN;
            EVEN:    if (out_ready) state_nxt = ODD;
            ODD:     if (out_ready) state_nxt = accept ? EVEN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            h0       <= '0;
            h1       <= '0;
            h2       <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                h2       <= h1;
                h1       <= h0;
                h0       <= in_data;
                out_data <= sum;
            end else if (even_hs) begin
                out_data <= sum;
            end
        end
    end

endmodule

// File: tb/tb_fir_interp2.sv
// Self-checking bench for fir_interp2: directed scenarios plus randomized handshakes,
// checked against a queue-based model of pending outputs computed from the filter equations.
module tb_fir_interp2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int nvec = 0;
    int nerr = 0;

    int hist[3];
    int expq[$];
    int got[$];

    always #5 clk = ~clk;

    fir_interp2 dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input int d);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = d;
        expq.push_back((hist[0] >> 5) + (hist[1] >> 3) + (hist[2] >> 1));
        expq.push_back((hist[0] >> 4) + (hist[1] >> 2));
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic ordy, output bit acc);
        bit exp_ready;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_ready = (expq.size() == 0) || (expq.size() == 1 && ordy);
        chk("in_ready", int'(in_ready), int'(exp_ready));
        chk("out_valid", int'(out_valid), int'(expq.size() != 0));
        if (expq.size() != 0) chk("out_data", int'(out_data), expq[0]);
        acc = v && in_ready;
        if (out_valid && ordy) begin
            got.push_back(int'(out_data));
            if (expq.size() != 0) void'(expq.pop_front());
        end
        if (acc) model_accept(int'(d));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        got.delete();
        hist = '{0, 0, 0};
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 1);
    endtask

    task automatic send(input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) step(1'b1, d, 1'b1, acc);
        chk("send_accepted", int'(acc), 1);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 10 && expq.size() != 0; i++) step(1'b0, 8'd0, 1'b1, acc);
        chk("drain_empty", expq.size(), 0);
        step(1'b0, 8'd0, 1'b1, acc);
    endtask

    task automatic chk_got(input string tag, input int exp[]);
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, got[i], exp[i]);
    endtask

    initial begin
        bit acc;
        bit rdy_log[20];
        bit val_log[20];

        // Impulse response
        do_reset();
        send(8'd255);
        for (int i = 0; i < 3; i++) send(8'd0);
        drain();
        chk_got("impulse", '{7, 15, 31, 63, 127, 0, 0, 0});

        // Full-rate constant stream
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'd255, 1'b1, acc);
            rdy_log[i] = acc;
            val_log[i] = out_valid;
        end
        drain();
        for (int i = 0; i < 20; i++) chk("rate_in_ready", int'(rdy_log[i]), (i % 2 == 0) ? 1 : 0);
        for (int i = 1; i < 20; i++) chk("rate_no_gap", int'(val_log[i]), 1);
        chk("steady_even", got.size() >= 20 ? got[18] : -1, 165);
        chk("steady_odd", got.size() >= 20 ? got[19] : -1, 78);

        // Backpressure with ignored input pulses in EVEN
        do_reset();
        send(8'd255);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'd99, 1'b0, acc);
            chk("bp_no_accept", int'(acc), 0);
            chk("bp_hold", int'(out_data), 7);
        end
        drain();
        chk_got("backpressure", '{7, 15});

        // ODD handshake coincident with new input
        do_reset();
        send(8'd0);
        step(1'b0, 8'd0, 1'b1, acc);
        step(1'b1, 8'd32, 1'b1, acc);
        chk("odd_accept", int'(acc), 1);
        drain();
        chk_got("odd_overlap", '{0, 0, 1, 2});

        // Reset while in ODD under backpressure
        do_reset();
        send(8'd255);
        step(1'b0, 8'd0, 1'b1, acc);
        step(1'b0, 8'd0, 1'b0, acc);
        do_reset();
        send(8'd64);
        drain();
        chk_got("post_reset", '{2, 4});

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0), acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
